mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory line address width.
REQ-002 Parameter LINE_W, default 128, line data width (8 x 16-bit words).
REQ-003 Parameter TIMEOUT, default 64, max cycles in a grant state waiting for mem_ack before abort; TIMEOUT SHALL be at least 2.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port i_req  in  1  fetch-side line read request, level, held until i_ack.
REQ-007 Port i_addr  in  ADDR_W  fetch-side line address, stable while i_req high.
REQ-008 Port i_ack  out  1  one-cycle completion pulse to fetch side.
REQ-009 Port i_rdata  out  LINE_W  line returned to fetch side, valid with i_ack.
REQ-010 Port d_req  in  1  data-side request, level, held until d_ack.
REQ-011 Port d_we  in  1  data-side direction, 1 = line write, 0 = line read; stable while d_req high.
REQ-012 Port d_addr  in  ADDR_W  data-side line address.
REQ-013 Port d_wdata  in  LINE_W  data-side write line.
REQ-014 Port d_ack  out  1  one-cycle completion pulse to data side.
REQ-015 Port d_rdata  out  LINE_W  line returned to data side, valid with d_ack on reads.
REQ-016 Port mem_req  out  1  registered request to main memory.
REQ-017 Port mem_we  out  1  registered memory write enable.
REQ-018 Port mem_addr  out  ADDR_W  registered memory address.
REQ-019 Port mem_wdata  out  LINE_W  registered memory write line.
REQ-020 Port mem_ack  in  1  memory completion pulse; mem_rdata valid in same cycle.
REQ-021 Port mem_rdata  in  LINE_W  memory read line.
REQ-022 Port err  out  1  sticky timeout flag.

Function
REQ-023 FSM states SHALL be IDLE, GNT_I, GNT_D, ACK; exactly one memory transaction outstanding at any time.
REQ-024 IDLE: only i_req high -> GNT_I; only d_req high -> GNT_D; both high -> grant side opposite to last_grant register; neither -> stay IDLE.
REQ-025 On entering GNT_x, mem_req=1 and mem_we/mem_addr/mem_wdata SHALL be registered from the granted side (mem_we=0, mem_wdata=0 for I side) in the same edge; last_grant updated (0=I, 1=D).
REQ-026 GNT_x with mem_ack=1: next edge -> ACK, mem_req=0, mem_we=0, granted side ack=1, read data registered into i_rdata or d_rdata.
REQ-027 D-side write completion SHALL leave d_rdata unchanged; i_rdata/d_rdata otherwise hold last value.
REQ-028 ACK lasts exactly one cycle, then -> IDLE unconditionally; requester drops req in the cycle after ack, so IDLE never re-grants a served request.
REQ-029 Latency: req high in IDLE at cycle t -> mem_req high at t+1; mem_ack at cycle k -> ack high at k+1; next grant earliest at k+3.
REQ-030 mem_ack received in IDLE or ACK SHALL be ignored.
REQ-031 Watchdog counter SHALL clear on grant entry and increment each GNT_x cycle without mem_ack; reaching TIMEOUT -> ACK with granted ack=1, returned rdata all zeros (reads), mem_req=0, err=1.
REQ-032 err SHALL stay 1 until reset; arbiter keeps operating after a timeout.
REQ-033 mem_ack in same cycle the counter reaches TIMEOUT SHALL complete normally, err unchanged.
REQ-034 Request inputs changing while not granted SHALL not disturb the active transaction.

Reset
REQ-035 reset low SHALL immediately force state IDLE, last_grant=0, counter=0, err=0, and all outputs (i_ack, d_ack, i_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata) to 0.
REQ-036 Reset mid-transaction SHALL abandon it with no ack pulse; first grant after release follows REQ-024 with last_grant=0.

Verification
REQ-037 i_req alone, i_addr=16'h0040, mem_ack 3 cycles after mem_req, mem_rdata=128'hA5..A5 -> one mem read addr 0040, i_ack one cycle with i_rdata=A5..A5, d_ack never.
REQ-038 i_req and d_req raised same cycle after reset -> D granted first (last_grant=0), then I; repeat with both held -> grants alternate D,I,D,I.
REQ-039 d_req, d_we=1, d_addr=16'h0100, d_wdata=128'h1234 -> mem_we=1, mem_wdata=1234, d_ack after mem_ack, d_rdata unchanged.
REQ-040 Memory never acks, TIMEOUT=64 -> i_ack at 64th grant cycle+1, i_rdata=0, err=1 and stays 1 through subsequent normal transactions.
REQ-041 reset asserted while in GNT_D -> mem_req=0 same cycle, no d_ack, err=0; after release pending i_req and d_req -> D granted.
REQ-042 mem_ack pulsed while IDLE with no requests -> no state change, no ack, rdata registers unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-side, data-side and main-memory signals around mem_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [LINE_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ack;
  logic [LINE_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) line arbiter in front of a single-outstanding main memory,
// with alternating priority on contention and a sticky watchdog timeout.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ACK} state_t;

  state_t            state, state_nx;
  logic              last_grant, last_grant_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              grant_d, timeout_hit;

  logic              mem_req_nx, mem_we_nx, i_ack_nx, d_ack_nx, err_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [LINE_W-1:0] mem_wdata_nx, i_rdata_nx, d_rdata_nx;

  // On contention the side that did not win last time is served.
  assign grant_d     = bus.d_req && (!bus.i_req || !last_grant);
  assign timeout_hit = !bus.mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: every flop below resets, including the line buffers, because the reset
  // state of all outputs is architecturally visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= 1'b0;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // pre-edge values regardless of statement order.
      state         <= state_nx;
      last_grant    <= last_grant_nx;
      cnt           <= cnt_nx;
      bus.mem_req   <= mem_req_nx;
      bus.mem_we    <= mem_we_nx;
      bus.mem_addr  <= mem_addr_nx;
      bus.mem_wdata <= mem_wdata_nx;
      bus.i_ack     <= i_ack_nx;
      bus.d_ack     <= d_ack_nx;
      bus.i_rdata   <= i_rdata_nx;
      bus.d_rdata   <= d_rdata_nx;
      bus.err       <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (bus.i_req || bus.d_req) state_nx = grant_d ? GNT_D : GNT_I;
      GNT_I, GNT_D: if (bus.mem_ack || timeout_hit) state_nx = ACK;
      ACK:          state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    last_grant_nx = last_grant;
    cnt_nx        = cnt;
    mem_req_nx    = bus.mem_req;
    mem_we_nx     = bus.mem_we;
    mem_addr_nx   = bus.mem_addr;
    mem_wdata_nx  = bus.mem_wdata;
    i_ack_nx      = 1'b0;
    d_ack_nx      = 1'b0;
    i_rdata_nx    = bus.i_rdata;
    d_rdata_nx    = bus.d_rdata;
    err_nx        = bus.err;

    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          mem_req_nx    = 1'b1;
          cnt_nx        = '0;
          last_grant_nx = grant_d;
          mem_we_nx     = grant_d ? bus.d_we    : 1'b0;
          mem_addr_nx   = grant_d ? bus.d_addr  : bus.i_addr;
          mem_wdata_nx  = grant_d ? bus.d_wdata : '0;
        end
      end
      GNT_I, GNT_D: begin
        if (!bus.mem_ack) cnt_nx = cnt + CNT_W'(1);
        if (bus.mem_ack || timeout_hit) begin
          mem_req_nx = 1'b0;
          mem_we_nx  = 1'b0;
          if (!bus.mem_ack) err_nx = 1'b1;
          if (state == GNT_I) begin
            i_ack_nx   = 1'b1;
            i_rdata_nx = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            d_ack_nx = 1'b1;
            // A completed write leaves the data-side read buffer untouched.
            if (!bus.mem_we) d_rdata_nx = bus.mem_ack ? bus.mem_rdata : '0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter: a transaction-level model predicts
// grant order, cycle timing, line data and the sticky error flag every cycle.
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int LINE_W  = 128;
  localparam int TIMEOUT = 64;

  logic clk;
  logic reset;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int cyc;

  // Reference model: last winner, sticky error, expected line buffers.
  logic              m_last_grant;
  logic              m_err;
  logic [LINE_W-1:0] m_i_rdata;
  logic [LINE_W-1:0] m_d_rdata;

  // Outstanding transaction as predicted by the model.
  bit                busy;
  bit                side;           // 1 = data side
  int                g;              // first cycle mem_req is visible
  int                ack_cycle;      // cycle the requester ack is visible
  int                mem_ack_at;     // cycle the memory model pulses mem_ack (-1 none)
  int                free_from;      // earliest cycle a new grant can be visible
  bit                t_timeout;
  logic              t_we;
  logic [ADDR_W-1:0] t_addr;
  logic [LINE_W-1:0] t_wdata;
  logic [LINE_W-1:0] t_line;

  // Stimulus knobs.
  int                cfg_p_i, cfg_p_d, cfg_we_pct;
  int                cfg_lat_min, cfg_lat_max, cfg_silent_pct;
  bit                cfg_spurious, cfg_fixed_data;
  logic [LINE_W-1:0] cfg_data;

  logic [LINE_W-1:0] saved_line;

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_last_grant = 1'b0;
    m_err        = 1'b0;
    m_i_rdata    = '0;
    m_d_rdata    = '0;
    busy         = 1'b0;
    mem_ack_at   = -1;
    free_from    = cyc + 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   bus.mem_req,   '0);
    check({tag, "_mem_we"},    bus.mem_we,    '0);
    check({tag, "_mem_addr"},  bus.mem_addr,  '0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    check({tag, "_i_ack"},     bus.i_ack,     '0);
    check({tag, "_d_ack"},     bus.d_ack,     '0);
    check({tag, "_i_rdata"},   bus.i_rdata,   '0);
    check({tag, "_d_rdata"},   bus.d_rdata,   '0);
    check({tag, "_err"},       bus.err,       '0);
  endtask

  // One clock per iteration: predict, compare, then act as requesters and memory.
  task automatic serve(input int n);
    for (int k = 0; k < n; k++) begin
      bit prev_i, prev_d, drop_i, drop_d, exp_i_ack, exp_d_ack, in_win;
      int lat;
      prev_i = bus.i_req;
      prev_d = bus.d_req;
      step();
      drop_i = 1'b0; drop_d = 1'b0; exp_i_ack = 1'b0; exp_d_ack = 1'b0;

      if (!busy && cyc >= free_from && (prev_i || prev_d)) begin
        side         = (prev_i && prev_d) ? !m_last_grant : prev_d;
        m_last_grant = side;
        busy         = 1'b1;
        g            = cyc;
        t_we         = side ? bus.d_we    : 1'b0;
        t_addr       = side ? bus.d_addr  : bus.i_addr;
        t_wdata      = side ? bus.d_wdata : '0;
        t_line       = cfg_fixed_data ? cfg_data : rand_line();
        lat          = $urandom_range(cfg_lat_max, cfg_lat_min);
        mem_ack_at   = ($urandom_range(99, 0) < cfg_silent_pct) ? -1 : g + lat;
        if (mem_ack_at >= 0 && lat <= TIMEOUT - 1) begin
          ack_cycle = mem_ack_at + 1;
          t_timeout = 1'b0;
        end else begin
          ack_cycle = g + TIMEOUT;
          t_timeout = 1'b1;
        end
      end

      in_win = busy && cyc < ack_cycle;
      if (busy && cyc == ack_cycle) begin
        if (side) begin
          exp_d_ack = 1'b1;
          if (!t_we) m_d_rdata = t_timeout ? '0 : t_line;
        end else begin
          exp_i_ack = 1'b1;
          m_i_rdata = t_timeout ? '0 : t_line;
        end
        if (t_timeout) m_err = 1'b1;
      end

      check("mem_req", bus.mem_req, in_win);
      check("mem_we",  bus.mem_we,  in_win ? t_we : 1'b0);
      if (in_win) begin
        check("mem_addr",  bus.mem_addr,  t_addr);
        check("mem_wdata", bus.mem_wdata, t_wdata);
      end
      check("i_ack",   bus.i_ack,   exp_i_ack);
      check("d_ack",   bus.d_ack,   exp_d_ack);
      check("i_rdata", bus.i_rdata, m_i_rdata);
      check("d_rdata", bus.d_rdata, m_d_rdata);
      check("err",     bus.err,     m_err);

      if (exp_i_ack || exp_d_ack) begin
        busy      = 1'b0;
        free_from = cyc + 2;
        if (exp_i_ack) begin bus.i_req = 1'b0; drop_i = 1'b1; end
        if (exp_d_ack) begin bus.d_req = 1'b0; drop_d = 1'b1; end
      end

      if (!bus.i_req && !drop_i) begin
        bus.i_addr = ADDR_W'($urandom);
        if ($urandom_range(99, 0) < cfg_p_i) bus.i_req = 1'b1;
      end
      if (!bus.d_req && !drop_d) begin
        bus.d_we    = ($urandom_range(99, 0) < cfg_we_pct);
        bus.d_addr  = ADDR_W'($urandom);
        bus.d_wdata = rand_line();
        if ($urandom_range(99, 0) < cfg_p_d) bus.d_req = 1'b1;
      end

      bus.mem_ack   = (cyc == mem_ack_at) ||
                      (!busy && cfg_spurious && $urandom_range(3, 0) == 0);
      bus.mem_rdata = (cyc == mem_ack_at) ? t_line : rand_line();
    end
  endtask

  task automatic drain();
    cfg_p_i = 0;
    cfg_p_d = 0;
    for (int k = 0; k < 300 && (busy || bus.i_req || bus.d_req); k++) serve(1);
    check("drain_idle", {busy, bus.i_req, bus.d_req}, '0);
    serve(2);
  endtask

  task automatic set_mem(input int lat_min, input int lat_max, input int silent_pct,
                         input bit spurious);
    cfg_lat_min    = lat_min;
    cfg_lat_max    = lat_max;
    cfg_silent_pct = silent_pct;
    cfg_spurious   = spurious;
    cfg_fixed_data = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    cfg_p_i = 0; cfg_p_d = 0; cfg_we_pct = 50;
    set_mem(0, 3, 0, 1'b0);
    cfg_data = '0;
    reset         = 1'b0;
    bus.i_req     = 1'b0; bus.i_addr  = '0;
    bus.d_req     = 1'b0; bus.d_we    = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack   = 1'b0; bus.mem_rdata = '0;
    #3;
    check_reset_outputs("por");
    step();
    step();
    reset = 1'b1;
    model_reset();

    // Both sides raise together right after reset and re-request immediately:
    // data side first, then strict alternation.
    cfg_p_i = 100; cfg_p_d = 100;
    set_mem(0, 3, 0, 1'b0);
    serve(40);
    drain();

    // Fetch read of line 0x0040, memory answers three cycles after mem_req.
    set_mem(3, 3, 0, 1'b0);
    cfg_fixed_data = 1'b1;
    cfg_data       = {16{8'hA5}};
    bus.i_addr = 16'h0040;
    bus.i_req  = 1'b1;
    serve(8);
    check("fetch_a5_rdata", bus.i_rdata, {16{8'hA5}});
    drain();

    // Data-side line write: d_rdata must not move.
    set_mem(0, 4, 0, 1'b0);
    saved_line  = m_d_rdata;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0100;
    bus.d_wdata = 128'h1234;
    bus.d_req   = 1'b1;
    serve(8);
    check("write_keeps_d_rdata", bus.d_rdata, saved_line);
    drain();

    // mem_ack on the last watchdog cycle still completes normally.
    set_mem(TIMEOUT - 1, TIMEOUT - 1, 0, 1'b0);
    bus.d_we  = 1'b0;
    bus.d_req = 1'b1;
    serve(TIMEOUT + 4);
    check("late_ack_no_err", bus.err, 1'b0);
    drain();

    // One cycle later is a timeout; the stray mem_ack lands in ACK and is ignored.
    set_mem(TIMEOUT, TIMEOUT, 0, 1'b0);
    bus.d_we  = 1'b0;
    bus.d_req = 1'b1;
    serve(TIMEOUT + 4);
    check("timeout_d_rdata", bus.d_rdata, '0);
    drain();

    // Silent memory on a fetch read, then normal traffic with err held high.
    set_mem(0, 0, 100, 1'b0);
    bus.i_req = 1'b1;
    serve(TIMEOUT + 4);
    check("timeout_i_rdata", bus.i_rdata, '0);
    check("timeout_err",     bus.err,     1'b1);
    set_mem(0, 5, 0, 1'b0);
    cfg_p_i = 30; cfg_p_d = 30;
    serve(80);
    drain();

    // Stray mem_ack pulses with nobody requesting.
    set_mem(0, 0, 0, 1'b1);
    serve(20);
    drain();

    // Randomised soak with occasional silent memory.
    set_mem(0, 8, 3, 1'b1);
    cfg_p_i = 20; cfg_p_d = 25;
    serve(3000);
    drain();

    // Reset while the data side is granted, with both sides pending at release.
    set_mem(0, 0, 100, 1'b0);
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0200;
    bus.d_req  = 1'b1;
    serve(3);
    #2;
    reset     = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    bus.i_addr = 16'h0300;
    bus.i_req  = 1'b1;
    step();
    check_reset_outputs("mid_rst_held");
    reset = 1'b1;
    model_reset();
    set_mem(1, 4, 0, 1'b0);
    serve(1);
    check("rst_regrant_d_addr", bus.mem_addr, 16'h0200);
    serve(30);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
